// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: state encoding and the board-level
// default tick divider used by the display and scoring blocks.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam int DEFAULT_TICK_DIV = 100_000_000;

endpackage

// File: rtl/countdown_sequencer_if.sv
// Request/status bundle between game control and the countdown sequencer.
// Requests are level-sampled on every rising edge; there is no valid/ready pair.
interface countdown_sequencer_if
  import countdown_pkg::*;
#(
  parameter int COUNT_W = 8
);
  logic               start;
  logic               pause;
  logic               abort;
  logic [COUNT_W-1:0] count;
  logic               busy;
  logic               expired;
  logic               done;
  state_t             state;

  modport master (
    output start, pause, abort,
    input  count, busy, expired, done, state
  );

  modport slave (
    input  start, pause, abort,
    output count, busy, expired, done, state
  );
endinterface

// File: rtl/countdown_sequencer_tick_prescaler.sv
// Divides the clock into a single-cycle tick every TICK_DIV enabled cycles.
// The count holds while enable is low, so a paused second resumes where it left off.
module tick_prescaler
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q;

  assign tick = enable && (cnt_q == LAST);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + PW'(1);
    end
  end
endmodule

// File: rtl/countdown_sequencer.sv
// Countdown run controller: IDLE/RUN/PAUSE/EXPIRED FSM owning the count register.
// Build with COUNTDOWN_PAUSE_EN defined to enable the pause input and PAUSE state.
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int START_VALUE = 5,
  parameter int COUNT_W     = 8,
  parameter int TICK_DIV    = DEFAULT_TICK_DIV
) (
  input  logic                  clock,
  input  logic                  reset,
  countdown_sequencer_if.slave  bus
);
  localparam logic [COUNT_W-1:0] START = COUNT_W'(START_VALUE);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               done_q, done_d;
  logic               presc_en, presc_clr, tick;
  logic               pause_req;

`ifdef COUNTDOWN_PAUSE_EN
  assign pause_req = bus.pause;
`else
  logic unused_pause;
  assign unused_pause = bus.pause;
  assign pause_req    = 1'b0;
`endif

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (presc_en),
    .clear  (presc_clr),
    .tick   (tick)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    done_d    = 1'b0;
    presc_en  = 1'b0;
    presc_clr = 1'b0;
    if (bus.abort) begin
      state_d   = IDLE;
      count_d   = START;
      presc_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE, EXPIRED: begin
          if (bus.start) begin
            count_d   = START;
            presc_clr = 1'b1;
            if (START_VALUE == 0) begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN, PAUSE: begin
          // Leaving PAUSE counts this cycle, so exactly the paused cycles are lost.
          if (pause_req) begin
            state_d = PAUSE;
          end else begin
            state_d  = RUN;
            presc_en = 1'b1;
            if (tick) begin
              if (count_q <= COUNT_W'(1)) begin
                count_d = '0;
                state_d = EXPIRED;
                done_d  = 1'b1;
              end else begin
                count_d = count_q - COUNT_W'(1);
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= START;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign bus.state   = state_q;
  assign bus.count   = count_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state_q == RUN) || (state_q == PAUSE);
  assign bus.expired = (state_q == EXPIRED);
endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer with TICK_DIV=4 (START_VALUE 5 and 0 instances).
// Pause expectations follow COUNTDOWN_PAUSE_EN.
module tb_countdown_sequencer;
  import countdown_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  countdown_sequencer_if #(.COUNT_W(8)) bus ();
  countdown_sequencer_if #(.COUNT_W(8)) zbus ();

  countdown_sequencer #(.START_VALUE(5), .COUNT_W(8), .TICK_DIV(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  countdown_sequencer #(.START_VALUE(0), .COUNT_W(8), .TICK_DIV(4)) dut_zero (
    .clock (clock),
    .reset (reset),
    .bus   (zbus.slave)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0;
    zbus.start = 1'b0; zbus.pause = 1'b0; zbus.abort = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    checks++; if (bus.count !== 8'd5) begin errors++; $display("FAIL reset_count got=%0d exp=5", bus.count); end
    checks++; if (bus.busy !== 1'b0 || bus.expired !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_flags busy=%b expired=%b done=%b exp=000", bus.busy, bus.expired, bus.done);
    end
    step();
    checks++; if (bus.state !== IDLE || bus.count !== 8'd5) begin
      errors++; $display("FAIL idle_hold state=%0d count=%0d exp state=0 count=5", bus.state, bus.count);
    end
  endtask

  task automatic test_count_run();
    logic [7:0] exp_c;
    do_reset();
    do_start();
    checks++; if (bus.busy !== 1'b1 || bus.state !== RUN || bus.count !== 8'd5) begin
      errors++; $display("FAIL run_entry busy=%b state=%0d count=%0d exp busy=1 state=1 count=5", bus.busy, bus.state, bus.count);
    end
    for (int k = 1; k <= 23; k++) begin
      step();
      exp_c = (k >= 20) ? 8'd0 : 8'(5 - k / 4);
      checks++; if (bus.count !== exp_c) begin errors++; $display("FAIL run_count k=%0d got=%0d exp=%0d", k, bus.count, exp_c); end
      checks++; if (bus.done !== (k == 20)) begin errors++; $display("FAIL run_done k=%0d got=%b exp=%b", k, bus.done, (k == 20)); end
      checks++; if (bus.expired !== (k >= 20)) begin errors++; $display("FAIL run_expired k=%0d got=%b exp=%b", k, bus.expired, (k >= 20)); end
    end
  endtask

  task automatic test_pause();
    int         eff;
    logic [7:0] exp_c;
    state_t     exp_s;
    do_reset();
    do_start();
    for (int k = 1; k <= 5; k++) step();
    for (int k = 6; k <= 32; k++) begin
      bus.pause = (k <= 15);
      step();
`ifdef COUNTDOWN_PAUSE_EN
      eff   = (k <= 15) ? 5 : k - 10;
      exp_s = (eff >= 20) ? EXPIRED : ((k <= 15) ? PAUSE : RUN);
`else
      eff   = k;
      exp_s = (eff >= 20) ? EXPIRED : RUN;
`endif
      exp_c = (eff >= 20) ? 8'd0 : 8'(5 - eff / 4);
      checks++; if (bus.count !== exp_c) begin errors++; $display("FAIL pause_count k=%0d got=%0d exp=%0d", k, bus.count, exp_c); end
      checks++; if (bus.state !== exp_s) begin errors++; $display("FAIL pause_state k=%0d got=%0d exp=%0d", k, bus.state, exp_s); end
      checks++; if (bus.done !== (eff == 20)) begin errors++; $display("FAIL pause_done k=%0d got=%b exp=%b", k, bus.done, (eff == 20)); end
    end
    bus.pause = 1'b0;
  endtask

  task automatic test_abort_on_tick();
    do_reset();
    do_start();
    for (int k = 1; k <= 19; k++) step();
    checks++; if (bus.count !== 8'd1) begin errors++; $display("FAIL abort_pre_count got=%0d exp=1", bus.count); end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    checks++; if (bus.state !== IDLE || bus.count !== 8'd5 || bus.done !== 1'b0) begin
      errors++; $display("FAIL abort_tick state=%0d count=%0d done=%b exp state=0 count=5 done=0", bus.state, bus.count, bus.done);
    end
    step();
    checks++; if (bus.done !== 1'b0 || bus.state !== IDLE || bus.busy !== 1'b0) begin
      errors++; $display("FAIL abort_after state=%0d done=%b busy=%b exp state=0 done=0 busy=0", bus.state, bus.done, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_c;
    do_reset();
    do_start();
    for (int k = 1; k <= 21; k++) step();
    checks++; if (bus.state !== EXPIRED || bus.count !== 8'd0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL b2b_expired state=%0d count=%0d done=%b exp state=3 count=0 done=0", bus.state, bus.count, bus.done);
    end
    do_start();
    checks++; if (bus.state !== RUN || bus.count !== 8'd5 || bus.done !== 1'b0) begin
      errors++; $display("FAIL b2b_restart state=%0d count=%0d done=%b exp state=1 count=5 done=0", bus.state, bus.count, bus.done);
    end
    for (int k = 1; k <= 20; k++) begin
      bus.start = (k == 10);
      step();
      exp_c = (k >= 20) ? 8'd0 : 8'(5 - k / 4);
      checks++; if (bus.count !== exp_c) begin errors++; $display("FAIL b2b_count k=%0d got=%0d exp=%0d", k, bus.count, exp_c); end
      checks++; if (bus.done !== (k == 20)) begin errors++; $display("FAIL b2b_done k=%0d got=%b exp=%b", k, bus.done, (k == 20)); end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    do_start();
    for (int k = 1; k <= 8; k++) step();
    checks++; if (bus.count !== 8'd3) begin errors++; $display("FAIL midreset_pre_count got=%0d exp=3", bus.count); end
    reset = 1'b1;
    step();
    checks++; if (bus.state !== IDLE || bus.count !== 8'd5 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.expired !== 1'b0) begin
      errors++; $display("FAIL midreset state=%0d count=%0d busy=%b done=%b expired=%b exp 0/5/0/0/0",
                         bus.state, bus.count, bus.busy, bus.done, bus.expired);
    end
    reset = 1'b0;
  endtask

  task automatic test_zero_start();
    do_reset();
    zbus.start = 1'b1;
    step();
    zbus.start = 1'b0;
    checks++; if (zbus.state !== EXPIRED || zbus.done !== 1'b1) begin
      errors++; $display("FAIL zero_entry state=%0d done=%b exp state=3 done=1", zbus.state, zbus.done);
    end
    checks++; if (zbus.count !== 8'd0 || zbus.expired !== 1'b1 || zbus.busy !== 1'b0) begin
      errors++; $display("FAIL zero_flags count=%0d expired=%b busy=%b exp 0/1/0", zbus.count, zbus.expired, zbus.busy);
    end
    step();
    checks++; if (zbus.done !== 1'b0 || zbus.count !== 8'd0 || zbus.state !== EXPIRED) begin
      errors++; $display("FAIL zero_hold done=%b count=%0d state=%0d exp 0/0/3", zbus.done, zbus.count, zbus.state);
    end
  endtask

  initial begin
    test_reset();
    test_count_run();
    test_pause();
    test_abort_on_tick();
    test_back_to_back();
    test_reset_mid_run();
    test_zero_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/countdown_sequencer.md
# countdown_sequencer

Run controller for the game's countdown timer. Takes start/pause/abort requests from the game control logic and divides the board clock into a 1-per-second decrement tick. Sequences the count from a configurable start value down to zero and signals expiry to the scoring/display logic. Owns the countdown register, so no other block drives the count.

## Interface
- START_VALUE, 5: value loaded on reset, abort and start; 0..2^COUNT_W-1
- COUNT_W, 8: count width in bits
- TICK_DIV, 100_000_000: clock cycles per decrement tick; must be ≥ 2
- clock  in  1  system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high; returns every register to its reset value on the next edge
- start  in  1  level-sampled; begins (or restarts) a run
- pause  in  1  level; while high in RUN, freezes the countdown (see Configuration)
- abort  in  1  level-sampled; cancels the run and reloads START_VALUE
- count  out  COUNT_W  current countdown value
- busy  out  1  high in RUN or PAUSE
- expired  out  1  high in EXPIRED
- done  out  1  single-cycle pulse on the edge that enters EXPIRED
- state  out  2  current state encoding, for debug/display

## Operation
- States: IDLE=0, RUN=1, PAUSE=2, EXPIRED=3.
- Reset values:
  - state = IDLE, count = START_VALUE, prescaler = 0
  - busy = 0, expired = 0, done = 0
- Input priority within a cycle: reset > abort > start > pause.
- IDLE:
  - start → RUN, with count = START_VALUE and prescaler = 0.
  - If START_VALUE == 0, start → EXPIRED directly, with done pulsed.
- RUN:
  - Prescaler increments every cycle.
  - When prescaler == TICK_DIV-1 (a tick), the prescaler wraps to 0 and count decrements by 1.
  - A tick with count == 1 sets count = 0, moves to EXPIRED and pulses done.
  - start in RUN is ignored; a run is never restarted mid-flight.
- PAUSE:
  - Prescaler and count hold their values.
  - pause low → RUN; the prescaler resumes from its held value, so no partial second is lost.
- EXPIRED:
  - count holds 0.
  - start → RUN with START_VALUE reloaded and prescaler = 0.
  - abort → IDLE.
- abort in RUN, PAUSE or EXPIRED → IDLE, with count = START_VALUE and prescaler = 0.
- Arithmetic:
  - count never wraps; a decrement is only applied when count ≥ 1.
  - Prescaler width is $clog2(TICK_DIV).
- Outputs are registered. busy and expired are decoded from the registered state.

## Timing
- Every request takes effect on the first rising edge at which it is sampled high.
- First decrement occurs TICK_DIV cycles after the edge that enters RUN.
- Total run time from start to done is START_VALUE×TICK_DIV cycles, plus any paused cycles.
- pause and tick in the same RUN cycle: pause wins. The tick is not applied, and the prescaler holds at TICK_DIV-1.
- abort and tick in the same cycle: abort wins, so no done pulse.
- done is high for exactly one cycle and never asserts in the same cycle as reset or abort.
- Reset mid-run: on the next edge every output is at its reset value. No done pulse.

## Configuration
- COUNTDOWN_PAUSE_EN defined:
  - PAUSE state and pause input behave as described above.
- COUNTDOWN_PAUSE_EN undefined:
  - pause is ignored and PAUSE is unreachable.
  - state encoding is unchanged, and state never reads 2.

## Structure
- Shared package countdown_pkg holds:
  - state encoding constants (IDLE/RUN/PAUSE/EXPIRED) and the 2-bit state typedef
  - default TICK_DIV, used by the display and scoring blocks
- One sub-module, tick_prescaler, is natural:
  - inputs: enable, clear
  - output: single-cycle tick every TICK_DIV enabled cycles
  - holds its value while enable is low
- FSM and count register stay in countdown_sequencer.

## Test plan
All scenarios use TICK_DIV=4 and START_VALUE=5 unless stated.
1. Reset, then start pulsed one cycle → busy=1 next edge; count 5,4,3,2,1,0 with one step every 4 cycles; done pulses one cycle when count reaches 0 (20 cycles after RUN entry); expired=1; count holds at 0.
2. Start, then pause high for 10 cycles after 6 cycles of RUN → state=2, count holds 4 for 10 cycles; after release, count reaches 3 two cycles later; done at 30 cycles from RUN entry. With COUNTDOWN_PAUSE_EN undefined → pause ignored; done at 20 cycles.
3. abort asserted on the same cycle as the count 1→0 tick → state=IDLE, count=5, done never asserts.
4. In EXPIRED, start → count=5 and RUN next edge; a second done pulse arrives 20 cycles later. start re-asserted mid-RUN → no effect on count.
5. reset asserted mid-run at count=3 → next edge: state=IDLE, count=5, busy=0, done=0.
6. START_VALUE=0, start → EXPIRED next edge, done pulses once, count stays 0.
